// File: rtl/ahb_master_seq.sv
// AHB-Lite master sequencer: turns a command (single or INCR burst) into AHB
// address phases, inserts BUSY cycles on request and pulses DONE when the
// final data phase of a command completes.
module ahb_master_seq #(
    parameter int ADDR_W = 26,
    parameter int LEN_W  = 4
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              CMD_VALID,
    input  logic              CMD_WRITE,
    input  logic              CMD_INCR,
    input  logic [LEN_W-1:0]  CMD_LEN,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    output logic              CMD_READY,
    input  logic              STALL,
    input  logic              HREADY,
    output logic [5:0]        state,
    output logic [1:0]        HTRANS,
    output logic [31:0]       HADDR,
    output logic              HWRITE,
    output logic [2:0]        HBURST,
    output logic              DONE
);

    typedef enum logic [5:0] {
        StIdle    = 6'b000001,
        StSburstW = 6'b000010,
        StSburstR = 6'b000100,
        StIncrbW  = 6'b001000,
        StIncrbR  = 6'b010000,
        StBusy    = 6'b100000
    } state_t;

    localparam logic [1:0] TrIdle   = 2'b00;
    localparam logic [1:0] TrBusy   = 2'b01;
    localparam logic [1:0] TrNonseq = 2'b10;
    localparam logic [1:0] TrSeq    = 2'b11;

    localparam logic [2:0] BurstSingle = 3'b000;
    localparam logic [2:0] BurstIncr   = 3'b001;

    state_t            state_q, state_d;
    logic [1:0]        htrans_q, htrans_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hburst_q, hburst_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;   // final data phase still outstanding
    logic              done_q, done_d;

    logic [ADDR_W-1:0] addr_next;
    logic              next_cross;

    assign addr_next  = addr_q + ADDR_W'(4);
    // A beat starting on a 1 KB boundary must restart with NONSEQ.
    assign next_cross = (addr_next[9:0] == 10'd0);

    assign state     = state_q;
    assign HTRANS    = htrans_q;
    assign HADDR     = 32'(addr_q);
    assign HWRITE    = hwrite_q;
    assign HBURST    = hburst_q;
    assign DONE      = done_q;
    // Gated by HRESET so the handshake drops immediately on an async reset.
    assign CMD_READY = (state_q == StIdle) && !pend_q && !HRESET;

    // Next-state and registered-output computation.
    always_comb begin
        state_d  = state_q;
        htrans_d = htrans_q;
        addr_d   = addr_q;
        hwrite_d = hwrite_q;
        hburst_d = hburst_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pend_q) begin
                    if (HREADY) begin
                        pend_d = 1'b0;
                        done_d = 1'b1;
                    end
                end else if (CMD_VALID) begin
                    htrans_d = TrNonseq;
                    addr_d   = CMD_ADDR;
                    hwrite_d = CMD_WRITE;
                    if (CMD_INCR) begin
                        state_d  = CMD_WRITE ? StIncrbW : StIncrbR;
                        hburst_d = BurstIncr;
                        cnt_d    = CMD_LEN;
                    end else begin
                        state_d  = CMD_WRITE ? StSburstW : StSburstR;
                        hburst_d = BurstSingle;
                        cnt_d    = '0;
                    end
                end
            end
            StSburstW, StSburstR: begin
                if (HREADY) begin
                    state_d  = StIdle;
                    htrans_d = TrIdle;
                    pend_d   = 1'b1;
                end
            end
            StIncrbW, StIncrbR: begin
                if (HREADY) begin
                    if (cnt_q == '0) begin
                        state_d  = StIdle;
                        htrans_d = TrIdle;
                        pend_d   = 1'b1;
                    end else begin
                        cnt_d  = cnt_q - LEN_W'(1);
                        addr_d = addr_next;
                        if (STALL) begin
                            state_d  = StBusy;
                            htrans_d = TrBusy;
                        end else begin
                            htrans_d = next_cross ? TrNonseq : TrSeq;
                        end
                    end
                end
            end
            StBusy: begin
                // HADDR already holds the pending beat address.
                if (HREADY && !STALL) begin
                    state_d  = hwrite_q ? StIncrbW : StIncrbR;
                    htrans_d = (addr_q[9:0] == 10'd0) ? TrNonseq : TrSeq;
                end
            end
            default: begin
                state_d  = StIdle;
                htrans_d = TrIdle;
            end
        endcase
    end

    // State register with asynchronous reset.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= StIdle;
            htrans_q <= TrIdle;
            addr_q   <= '0;
            hwrite_q <= 1'b0;
            hburst_q <= BurstSingle;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            htrans_q <= htrans_d;
            addr_q   <= addr_d;
            hwrite_q <= hwrite_d;
            hburst_q <= hburst_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_ahb_master_seq.sv
// Directed self-checking bench for ahb_master_seq.
module tb_ahb_master_seq;

    localparam int ADDR_W = 26;
    localparam int LEN_W  = 4;

    localparam logic [5:0] S_IDLE    = 6'b000001;
    localparam logic [5:0] S_SBURSTW = 6'b000010;
    localparam logic [5:0] S_SBURSTR = 6'b000100;
    localparam logic [5:0] S_INCRBW  = 6'b001000;
    localparam logic [5:0] S_INCRBR  = 6'b010000;
    localparam logic [5:0] S_BUSY    = 6'b100000;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    logic              HCLK;
    logic              HRESET;
    logic              CMD_VALID;
    logic              CMD_WRITE;
    logic              CMD_INCR;
    logic [LEN_W-1:0]  CMD_LEN;
    logic [ADDR_W-1:0] CMD_ADDR;
    logic              CMD_READY;
    logic              STALL;
    logic              HREADY;
    logic [5:0]        state;
    logic [1:0]        HTRANS;
    logic [31:0]       HADDR;
    logic              HWRITE;
    logic [2:0]        HBURST;
    logic              DONE;

    int tests = 0;
    int fails = 0;

    ahb_master_seq #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .CMD_VALID (CMD_VALID),
        .CMD_WRITE (CMD_WRITE),
        .CMD_INCR  (CMD_INCR),
        .CMD_LEN   (CMD_LEN),
        .CMD_ADDR  (CMD_ADDR),
        .CMD_READY (CMD_READY),
        .STALL     (STALL),
        .HREADY    (HREADY),
        .state     (state),
        .HTRANS    (HTRANS),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HBURST    (HBURST),
        .DONE      (DONE)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Full check of the address-phase outputs and handshake.
    task automatic chk(input string tag, input logic [5:0] st, input logic [1:0] tr,
                       input logic [31:0] ad, input logic wr, input logic [2:0] bu,
                       input logic dn, input logic rd);
        logic [45:0] obs, exp;
        obs = {state, HTRANS, HADDR, HWRITE, HBURST, DONE, CMD_READY};
        exp = {st, tr, ad, wr, bu, dn, rd};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: {st,tr,addr,wr,burst,done,rdy} got %h expected %h", tag, obs, exp);
        end
    endtask

    // Check while idle: address-phase payload is don't-care there.
    task automatic chk_idle(input string tag, input logic dn, input logic rd);
        logic [9:0] obs, exp;
        obs = {state, HTRANS, DONE, CMD_READY};
        exp = {S_IDLE, T_IDLE, dn, rd};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: {st,tr,done,rdy} got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic incr, input logic [LEN_W-1:0] len,
                         input logic [ADDR_W-1:0] ad);
        CMD_VALID = 1'b1;
        CMD_WRITE = wr;
        CMD_INCR  = incr;
        CMD_LEN   = len;
        CMD_ADDR  = ad;
    endtask

    initial begin
        HRESET    = 1'b1;
        CMD_VALID = 1'b0;
        CMD_WRITE = 1'b0;
        CMD_INCR  = 1'b0;
        CMD_LEN   = '0;
        CMD_ADDR  = '0;
        STALL     = 1'b0;
        HREADY    = 1'b1;

        // Reset state and first cycle after release.
        #2;
        chk("reset", S_IDLE, T_IDLE, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        tick();
        HRESET = 1'b0;
        #1;
        chk_idle("post_reset_ready", 1'b0, 1'b1);

        // Single read at 0x0200001 with low bits masked.
        issue(1'b0, 1'b0, 4'd5, 26'h0200001 & ~26'h3);
        tick();
        CMD_VALID = 1'b0;
        chk("sr_addr", S_SBURSTR, T_NSEQ, 32'h0020_0000, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        chk_idle("sr_data", 1'b0, 1'b0);
        tick();
        chk_idle("sr_done", 1'b1, 1'b1);
        tick();
        chk_idle("sr_done_clr", 1'b0, 1'b1);

        // Single write with two wait states in the address phase.
        issue(1'b1, 1'b0, 4'd0, 26'h40);
        tick();
        CMD_VALID = 1'b0;
        HREADY    = 1'b0;
        chk("sw_hold1", S_SBURSTW, T_NSEQ, 32'h40, 1'b1, 3'b000, 1'b0, 1'b0);
        tick();
        chk("sw_hold2", S_SBURSTW, T_NSEQ, 32'h40, 1'b1, 3'b000, 1'b0, 1'b0);
        tick();
        chk("sw_hold3", S_SBURSTW, T_NSEQ, 32'h40, 1'b1, 3'b000, 1'b0, 1'b0);
        HREADY = 1'b1;
        tick();
        chk_idle("sw_data", 1'b0, 1'b0);
        HREADY = 1'b0;
        tick();
        chk_idle("sw_data_wait", 1'b0, 1'b0);
        HREADY = 1'b1;
        tick();
        chk_idle("sw_done", 1'b1, 1'b1);
        tick();
        chk_idle("sw_done_clr", 1'b0, 1'b1);

        // INCR read, 3 beats at 0x100.
        issue(1'b0, 1'b1, 4'd2, 26'h100);
        tick();
        CMD_VALID = 1'b0;
        chk("ir_b0", S_INCRBR, T_NSEQ, 32'h100, 1'b0, 3'b001, 1'b0, 1'b0);
        tick();
        chk("ir_b1", S_INCRBR, T_SEQ, 32'h104, 1'b0, 3'b001, 1'b0, 1'b0);
        tick();
        chk("ir_b2", S_INCRBR, T_SEQ, 32'h108, 1'b0, 3'b001, 1'b0, 1'b0);
        tick();
        chk_idle("ir_end", 1'b0, 1'b0);
        tick();
        chk_idle("ir_done", 1'b1, 1'b1);
        tick();
        chk_idle("ir_done_once", 1'b0, 1'b1);

        // INCR write, 4 beats, two BUSY cycles after beat 1, wait state on
        // beat 3, STALL ignored on the final beat.
        issue(1'b1, 1'b1, 4'd3, 26'h0);
        tick();
        CMD_VALID = 1'b0;
        STALL     = 1'b1;
        chk("iw_b0", S_INCRBW, T_NSEQ, 32'h0, 1'b1, 3'b001, 1'b0, 1'b0);
        tick();
        chk("iw_busy1", S_BUSY, T_BUSY, 32'h4, 1'b1, 3'b001, 1'b0, 1'b0);
        tick();
        chk("iw_busy2", S_BUSY, T_BUSY, 32'h4, 1'b1, 3'b001, 1'b0, 1'b0);
        STALL = 1'b0;
        tick();
        chk("iw_b1", S_INCRBW, T_SEQ, 32'h4, 1'b1, 3'b001, 1'b0, 1'b0);
        tick();
        chk("iw_b2", S_INCRBW, T_SEQ, 32'h8, 1'b1, 3'b001, 1'b0, 1'b0);
        HREADY = 1'b0;
        tick();
        chk("iw_b2_hold", S_INCRBW, T_SEQ, 32'h8, 1'b1, 3'b001, 1'b0, 1'b0);
        HREADY = 1'b1;
        tick();
        chk("iw_b3", S_INCRBW, T_SEQ, 32'hC, 1'b1, 3'b001, 1'b0, 1'b0);
        STALL = 1'b1;
        tick();
        STALL = 1'b0;
        chk_idle("iw_end", 1'b0, 1'b0);
        tick();
        chk_idle("iw_done", 1'b1, 1'b1);

        // INCR read across a 1 KB boundary; STALL at acceptance is ignored.
        issue(1'b0, 1'b1, 4'd3, 26'h3F8);
        STALL = 1'b1;
        tick();
        CMD_VALID = 1'b0;
        STALL     = 1'b0;
        chk("kb_b0", S_INCRBR, T_NSEQ, 32'h3F8, 1'b0, 3'b001, 1'b0, 1'b0);
        tick();
        chk("kb_b1", S_INCRBR, T_SEQ, 32'h3FC, 1'b0, 3'b001, 1'b0, 1'b0);
        tick();
        chk("kb_b2", S_INCRBR, T_NSEQ, 32'h400, 1'b0, 3'b001, 1'b0, 1'b0);
        tick();
        chk("kb_b3", S_INCRBR, T_SEQ, 32'h404, 1'b0, 3'b001, 1'b0, 1'b0);
        tick();
        chk_idle("kb_end", 1'b0, 1'b0);
        tick();
        chk_idle("kb_done", 1'b1, 1'b1);

        // Address wraps modulo 2^ADDR_W; a command held while not ready
        // waits for the outstanding data phase.
        issue(1'b0, 1'b1, 4'd1, 26'h3FF_FFFC);
        tick();
        CMD_VALID = 1'b0;
        chk("wr_b0", S_INCRBR, T_NSEQ, 32'h03FF_FFFC, 1'b0, 3'b001, 1'b0, 1'b0);
        tick();
        chk("wr_b1", S_INCRBR, T_NSEQ, 32'h0, 1'b0, 3'b001, 1'b0, 1'b0);
        tick();
        chk_idle("wr_end", 1'b0, 1'b0);
        issue(1'b0, 1'b0, 4'd0, 26'h10);
        tick();
        chk_idle("wr_done_no_accept", 1'b1, 1'b1);
        tick();
        CMD_VALID = 1'b0;
        chk("late_cmd", S_SBURSTR, T_NSEQ, 32'h10, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        chk_idle("late_end", 1'b0, 1'b0);
        tick();
        chk_idle("late_done", 1'b1, 1'b1);

        // Asynchronous reset during beat 2 of a burst.
        issue(1'b1, 1'b1, 4'd3, 26'h800);
        tick();
        CMD_VALID = 1'b0;
        chk("rst_b0", S_INCRBW, T_NSEQ, 32'h800, 1'b1, 3'b001, 1'b0, 1'b0);
        tick();
        chk("rst_b1", S_INCRBW, T_SEQ, 32'h804, 1'b1, 3'b001, 1'b0, 1'b0);
        #2;
        HRESET = 1'b1;
        #1;
        chk("rst_async", S_IDLE, T_IDLE, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        tick();
        HRESET = 1'b0;
        #1;
        chk_idle("rst_release", 1'b0, 1'b1);
        tick();
        chk_idle("rst_no_done", 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb_master_seq.md
AHB_MASTER_SEQ -- requirements
Module: ahb_master_seq

Interface
Parameters
REQ-001 The block SHALL have parameter ADDR_W, default 26, the width of the command byte address.
REQ-002 The block SHALL have parameter LEN_W, default 4, the width of the beat count; a burst is CMD_LEN+1 beats, 1..16.

Ports (name, direction, width, meaning)
REQ-003 The block SHALL have port HCLK, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port HRESET, input, 1, an asynchronous active-high reset.
REQ-005 The block SHALL have port CMD_VALID, input, 1, command request.
- CMD_WRITE, input, 1: 1 means write, 0 means read.
- CMD_INCR, input, 1: 0 means single transfer, 1 means INCR burst.
- CMD_LEN, input, LEN_W: beats minus 1; ignored when CMD_INCR=0.
- CMD_ADDR, input, ADDR_W: start byte address, word aligned.
- CMD_READY, output, 1: command accepted when CMD_VALID & CMD_READY.
REQ-006 The block SHALL have port STALL, input, 1, a source/sink not-ready request for BUSY insertion.
REQ-007 The block SHALL have port HREADY, input, 1, the AHB transfer-complete input.
REQ-008 The block SHALL have port state, output, 6, a one-hot sequencing state driving the read/write handlers.
REQ-009 The block SHALL have the following AHB address-phase outputs:
- HTRANS, output, 2: AHB transfer type.
- HADDR, output, 32: zero-extended ADDR_W address.
- HWRITE, output, 1: AHB write flag.
- HBURST, output, 3: 000 SINGLE, 001 INCR.
REQ-010 The block SHALL have port DONE, output, 1, a one-cycle pulse when the final data phase of a command completes.

Function
REQ-011 state encoding SHALL be IDLE=000001, SBURSTW=000010, SBURSTR=000100, INCRBW=001000, INCRBR=010000, BUSY=100000; exactly one bit SHALL be set at all times.
REQ-012 CMD_READY SHALL be 1 only when state=IDLE and no data phase is outstanding.
REQ-013 On acceptance, in the next cycle, state SHALL be SBURSTW/SBURSTR (CMD_INCR=0) or INCRBW/INCRBR (CMD_INCR=1), selected by CMD_WRITE; HTRANS SHALL be NONSEQ(10), HADDR SHALL be CMD_ADDR, HWRITE SHALL be CMD_WRITE, and HBURST SHALL be set per command.
REQ-014 An address phase SHALL be accepted on a rising edge with HREADY=1; while HREADY=0, state, HTRANS, HADDR, HWRITE and HBURST SHALL hold.
REQ-015 A single transfer SHALL return to IDLE (HTRANS=00) after its one address phase is accepted.
REQ-016 In an INCR burst, each accepted beat SHALL decrement an internal beat counter loaded with CMD_LEN; the next beat SHALL drive HTRANS=SEQ(11) and HADDR+4.
REQ-017 After the last beat (counter=0) is accepted, state SHALL be IDLE and HTRANS=IDLE.
REQ-018 If STALL=1 when a non-final INCR beat is accepted, the next state SHALL be BUSY with HTRANS=BUSY(01) and HADDR already at the next beat address; the counter SHALL not decrement on BUSY cycles.
REQ-019 BUSY SHALL exit to INCRBW/INCRBR with HTRANS=SEQ on the first rising edge with STALL=0 and HREADY=1; STALL SHALL be ignored for single transfers, the first beat decision of a burst, and the final beat.
REQ-020 When the next INCR beat address crosses a 1 KB boundary (HADDR[9:0] wraps to 0), that beat SHALL be issued with HTRANS=NONSEQ and HADDR continuing linearly with no wrap.
REQ-021 DONE SHALL pulse for one cycle on the edge after the final beat's data phase completes with HREADY=1; DONE SHALL never coincide with CMD_READY=0 in IDLE beyond that cycle.
REQ-022 HADDR arithmetic SHALL be modulo 2^ADDR_W; HADDR[31:ADDR_W] SHALL always be 0.

Reset
REQ-023 HRESET=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, HTRANS=00, HADDR=0, HWRITE=0, HBURST=000, DONE=0, CMD_READY=0, and clear the beat counter and outstanding-data flag.
REQ-024 In the first cycle after HRESET deasserts, CMD_READY SHALL be 1.
REQ-025 A reset mid-burst SHALL abandon the burst with no DONE pulse.

Verification
REQ-026 Single read: CMD_ADDR=0x0200001 & 0x3 masked, i.e. 0x0200000, CMD_INCR=0, HREADY=1 -> SBURSTR/NONSEQ/HADDR=0x0200000 for one cycle, then IDLE, DONE one cycle later.
REQ-027 Single write with HREADY=0 for 2 cycles in the address phase -> SBURSTW/NONSEQ/HWRITE=1 held 3 cycles, then IDLE, DONE after HREADY returns in the data phase.
REQ-028 INCR read, CMD_LEN=2, addr 0x100 -> INCRBR: NONSEQ 0x100, SEQ 0x104, SEQ 0x108, then IDLE; DONE once.
REQ-029 INCR write, CMD_LEN=3, STALL=1 for 2 cycles after beat 1 -> 0x000 NONSEQ, 0x004 BUSY x2, 0x004 SEQ, 0x008 SEQ, 0x00C SEQ; 4 beats total.
REQ-030 INCR read at 0x3F8, CMD_LEN=3 -> 0x3F8 NONSEQ, 0x3FC SEQ, 0x400 NONSEQ, 0x404 SEQ.
REQ-031 HRESET pulsed asynchronously mid-burst during beat 2 -> outputs IDLE/zero before the next edge, no DONE, CMD_READY=1 on the first cycle after release.
